// File: rtl/pid_lock_supervisor.sv
// Lock supervisor for a PID loop: output limiting with railed flags, lost-lock
// debounce and automatic triangle-sweep relock with catch/settle qualification.
module pid_lock_supervisor (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic signed [13:0] pid_dat_i,
    input  logic signed [13:0] mon_i,
    input  logic               lock_en_i,
    input  logic               relock_en_i,
    input  logic signed [13:0] lim_lo_i,
    input  logic signed [13:0] lim_hi_i,
    input  logic signed [13:0] mon_thr_i,
    input  logic [15:0]        lost_cyc_i,
    input  logic [15:0]        settle_cyc_i,
    input  logic [13:0]        sweep_step_i,
    input  logic [15:0]        sweep_div_i,
    output logic signed [13:0] dat_o,
    output logic [1:0]         railed_o,
    output logic               hold_o,
    output logic               int_rst_o,
    output logic               int_ctr_rst_o,
    output logic signed [13:0] int_ctr_val_o,
    output logic [2:0]         state_o,
    output logic [15:0]        relock_cnt_o
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StLocked   = 3'd1,
        StUnlocked = 3'd2,
        StSweep    = 3'd3,
        StCatch    = 3'd4,
        StSettle   = 3'd5
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [15:0]        r_lost_cnt;
    logic [15:0]        r_settle_cnt;
    logic [15:0]        r_div_cnt;
    logic [15:0]        r_relock_cnt;
    logic signed [13:0] r_sweep;
    logic               r_dir_down;
    logic signed [13:0] r_dat;
    logic [1:0]         r_railed;

    logic               w_mon_low;
    logic               w_lim_inv;
    logic               w_at_lo;
    logic               w_at_hi;
    logic signed [14:0] w_lo_ext;
    logic signed [14:0] w_hi_ext;
    logic signed [14:0] w_sum_up;
    logic signed [14:0] w_sum_dn;
    logic signed [13:0] w_sweep_adv;
    logic               w_dir_adv;

    assign w_mon_low = mon_i < mon_thr_i;
    assign w_lim_inv = lim_lo_i > lim_hi_i;
    assign w_at_lo   = pid_dat_i <= lim_lo_i;
    assign w_at_hi   = pid_dat_i >= lim_hi_i;

    always_comb begin
        w_state_next = r_state;
        if (!lock_en_i) begin
            w_state_next = StIdle;
        end else begin
            case (r_state)
                StIdle:     w_state_next = StLocked;
                StLocked: begin
                    if (w_mon_low && (r_lost_cnt == lost_cyc_i)) begin
                        w_state_next = relock_en_i ? StSweep : StUnlocked;
                    end
                end
                StUnlocked: w_state_next = StUnlocked;
                StSweep: begin
                    if (!w_mon_low) w_state_next = StCatch;
                end
                StCatch:    w_state_next = StSettle;
                StSettle: begin
                    if (w_mon_low) begin
                        w_state_next = StSweep;
                    end else if (r_settle_cnt == settle_cyc_i) begin
                        w_state_next = StLocked;
                    end
                end
                default:    w_state_next = StIdle;
            endcase
        end
    end

    // Triangle step evaluated at 15 bits so a step past a limit is caught before wrapping.
    assign w_lo_ext = {lim_lo_i[13], lim_lo_i};
    assign w_hi_ext = {lim_hi_i[13], lim_hi_i};
    assign w_sum_up = {r_sweep[13], r_sweep} + {1'b0, sweep_step_i};
    assign w_sum_dn = {r_sweep[13], r_sweep} - {1'b0, sweep_step_i};

    always_comb begin
        w_sweep_adv = r_sweep;
        w_dir_adv   = r_dir_down;
        if (!r_dir_down) begin
            if (w_sum_up >= w_hi_ext) begin
                w_sweep_adv = lim_hi_i;
                w_dir_adv   = 1'b1;
            end else begin
                w_sweep_adv = w_sum_up[13:0];
            end
        end else begin
            if (w_sum_dn <= w_lo_ext) begin
                w_sweep_adv = lim_lo_i;
                w_dir_adv   = 1'b0;
            end else begin
                w_sweep_adv = w_sum_dn[13:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= StIdle;
            r_lost_cnt   <= '0;
            r_settle_cnt <= '0;
            r_relock_cnt <= '0;
        end else begin
            r_state <= w_state_next;

            if (r_state == StLocked && w_mon_low) r_lost_cnt <= r_lost_cnt + 16'd1;
            else                                  r_lost_cnt <= '0;

            if (r_state == StSettle && !w_mon_low) r_settle_cnt <= r_settle_cnt + 16'd1;
            else                                   r_settle_cnt <= '0;

            if (w_state_next == StIdle) begin
                r_relock_cnt <= '0;
            end else if (r_state == StSettle && w_state_next == StLocked &&
                         r_relock_cnt != 16'hFFFF) begin
                r_relock_cnt <= r_relock_cnt + 16'd1;
            end
        end
    end

    // Sweep only advances while staying in SWEEP, so the catch point is the value held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sweep    <= '0;
            r_dir_down <= 1'b0;
            r_div_cnt  <= '0;
        end else if (r_state != StSweep && w_state_next == StSweep) begin
            r_sweep    <= lim_lo_i;
            r_dir_down <= 1'b0;
            r_div_cnt  <= '0;
        end else if (r_state == StSweep && w_state_next == StSweep) begin
            if (r_div_cnt == sweep_div_i) begin
                r_div_cnt  <= '0;
                r_sweep    <= w_sweep_adv;
                r_dir_down <= w_dir_adv;
            end else begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dat    <= '0;
            r_railed <= '0;
        end else if (w_lim_inv) begin
            r_dat    <= lim_lo_i;
            r_railed <= 2'b11;
        end else if (r_state == StSweep || r_state == StCatch) begin
            r_dat    <= r_sweep;
            r_railed <= 2'b00;
        end else begin
            r_railed <= {w_at_hi, w_at_lo};
            if (w_at_lo)      r_dat <= lim_lo_i;
            else if (w_at_hi) r_dat <= lim_hi_i;
            else              r_dat <= pid_dat_i;
        end
    end

    assign dat_o         = r_dat;
    assign railed_o      = r_railed;
    assign int_rst_o     = (r_state == StIdle) || (r_state == StSweep);
    assign hold_o        = (r_state == StUnlocked);
    assign int_ctr_rst_o = (r_state == StCatch);
    assign int_ctr_val_o = r_sweep;
    assign state_o       = r_state;
    assign relock_cnt_o  = r_relock_cnt;

endmodule

// File: tb/tb_pid_lock_supervisor.sv
// Directed bench for pid_lock_supervisor: clamp, debounce, sweep, relock,
// settle failure, priority and asynchronous reset.
module tb_pid_lock_supervisor;

    logic               clk;
    logic               rst;
    logic signed [13:0] pid;
    logic signed [13:0] mon;
    logic               lock_en;
    logic               relock_en;
    logic signed [13:0] lim_lo;
    logic signed [13:0] lim_hi;
    logic signed [13:0] thr;
    logic [15:0]        lost;
    logic [15:0]        settle;
    logic [13:0]        step;
    logic [15:0]        div;
    logic signed [13:0] dat;
    logic [1:0]         railed;
    logic               hold;
    logic               int_rst;
    logic               ctr_rst;
    logic signed [13:0] ctr_val;
    logic [2:0]         state;
    logic [15:0]        relock_cnt;

    int checks;
    int failures;

    pid_lock_supervisor dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pid_dat_i     (pid),
        .mon_i         (mon),
        .lock_en_i     (lock_en),
        .relock_en_i   (relock_en),
        .lim_lo_i      (lim_lo),
        .lim_hi_i      (lim_hi),
        .mon_thr_i     (thr),
        .lost_cyc_i    (lost),
        .settle_cyc_i  (settle),
        .sweep_step_i  (step),
        .sweep_div_i   (div),
        .dat_o         (dat),
        .railed_o      (railed),
        .hold_o        (hold),
        .int_rst_o     (int_rst),
        .int_ctr_rst_o (ctr_rst),
        .int_ctr_val_o (ctr_val),
        .state_o       (state),
        .relock_cnt_o  (relock_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_defaults;
        rst       = 1'b0;
        pid       = '0;
        mon       = 14'sd200;
        lock_en   = 1'b0;
        relock_en = 1'b0;
        lim_lo    = -14'sd1000;
        lim_hi    = 14'sd1000;
        thr       = 14'sd100;
        lost      = 16'd3;
        settle    = 16'd9;
        step      = 14'd30;
        div       = 16'd0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic go_locked;
        do_reset();
        lock_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic sweep_setup;
        set_defaults();
        lim_lo    = 14'sd0;
        lim_hi    = 14'sd100;
        lost      = 16'd0;
        relock_en = 1'b1;
    endtask

    task automatic test_reset;
        set_defaults();
        do_reset();
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=0", state);
        end
        lock_en = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("FAIL first_edge_locked got=%0d exp=1", state);
        end
        pid = 14'sd500;
        @(negedge clk);
        checks++;
        if (dat !== 14'sd500) begin
            failures++;
            $display("FAIL pass_through got=%0d exp=500", dat);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({state, dat, railed, int_rst, hold, ctr_rst, ctr_val, relock_cnt} !==
            {3'd0, 14'd0, 2'b00, 1'b1, 1'b0, 1'b0, 14'd0, 16'd0}) begin
            failures++;
            $display("FAIL async_reset got st=%0d dat=%0d rl=%b ir=%b h=%b cr=%b cv=%0d rc=%0d exp st=0 dat=0 rl=00 ir=1 h=0 cr=0 cv=0 rc=0",
                     state, dat, railed, int_rst, hold, ctr_rst, ctr_val, relock_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clamp;
        logic signed [13:0] pv[6] = '{14'sd1500, -14'sd2000, 14'sd123,
                                      14'sd1000, -14'sd1000, 14'sd999};
        logic signed [13:0] ev[6] = '{14'sd1000, -14'sd1000, 14'sd123,
                                      14'sd1000, -14'sd1000, 14'sd999};
        logic [1:0]         rv[6] = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00};
        set_defaults();
        go_locked();
        for (int i = 0; i < 6; i++) begin
            pid = pv[i];
            @(negedge clk);
            checks++;
            if (dat !== ev[i] || railed !== rv[i]) begin
                failures++;
                $display("FAIL clamp_%0d got dat=%0d rl=%b exp dat=%0d rl=%b",
                         i, dat, railed, ev[i], rv[i]);
            end
        end
        pid = 14'sd200;
        #1;
        checks++;
        if (dat !== 14'sd999) begin
            failures++;
            $display("FAIL clamp_latency got=%0d exp=999", dat);
        end
    endtask

    task automatic test_debounce;
        set_defaults();
        go_locked();
        mon = '0;
        repeat (3) @(negedge clk);
        mon = 14'sd200;
        @(negedge clk);
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("FAIL debounce_3_low got=%0d exp=1", state);
        end
        mon = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("FAIL debounce_boundary got=%0d exp=1", state);
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd2 || hold !== 1'b1 || int_rst !== 1'b0) begin
            failures++;
            $display("FAIL debounce_unlocked got st=%0d h=%b ir=%b exp st=2 h=1 ir=0",
                     state, hold, int_rst);
        end
        mon = 14'sd200;
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 3'd2) begin
            failures++;
            $display("FAIL unlocked_sticky got=%0d exp=2", state);
        end
        lock_en = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || hold !== 1'b0) begin
            failures++;
            $display("FAIL unlocked_to_idle got st=%0d h=%b exp st=0 h=0", state, hold);
        end
    endtask

    task automatic test_sweep;
        logic signed [13:0] ev[10] = '{14'sd0, 14'sd30, 14'sd60, 14'sd90, 14'sd100,
                                       14'sd70, 14'sd40, 14'sd10, 14'sd0, 14'sd30};
        sweep_setup();
        go_locked();
        mon = '0;
        @(negedge clk);
        checks++;
        if (state !== 3'd3 || int_rst !== 1'b1) begin
            failures++;
            $display("FAIL sweep_entry got st=%0d ir=%b exp st=3 ir=1", state, int_rst);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (dat !== ev[i] || railed !== 2'b00) begin
                failures++;
                $display("FAIL sweep_%0d got dat=%0d rl=%b exp dat=%0d rl=00",
                         i, dat, railed, ev[i]);
            end
        end
    endtask

    task automatic test_sweep_div;
        logic signed [13:0] ev[6] = '{14'sd0, 14'sd0, 14'sd30, 14'sd30, 14'sd60, 14'sd60};
        sweep_setup();
        div = 16'd1;
        go_locked();
        mon = '0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (dat !== ev[i]) begin
                failures++;
                $display("FAIL sweep_div_%0d got=%0d exp=%0d", i, dat, ev[i]);
            end
        end
    endtask

    task automatic test_relock;
        sweep_setup();
        go_locked();
        mon = '0;
        repeat (3) @(negedge clk);
        mon = 14'sd200;
        @(negedge clk);
        checks++;
        if (state !== 3'd4 || ctr_rst !== 1'b1 || ctr_val !== 14'sd60 || int_rst !== 1'b0) begin
            failures++;
            $display("FAIL catch got st=%0d cr=%b cv=%0d ir=%b exp st=4 cr=1 cv=60 ir=0",
                     state, ctr_rst, ctr_val, int_rst);
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd5 || ctr_rst !== 1'b0 || dat !== 14'sd60 || ctr_val !== 14'sd60) begin
            failures++;
            $display("FAIL settle_entry got st=%0d cr=%b dat=%0d cv=%0d exp st=5 cr=0 dat=60 cv=60",
                     state, ctr_rst, dat, ctr_val);
        end
        repeat (9) @(negedge clk);
        checks++;
        if (state !== 3'd5 || relock_cnt !== 16'd0) begin
            failures++;
            $display("FAIL settle_hold got st=%0d rc=%0d exp st=5 rc=0", state, relock_cnt);
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd1 || relock_cnt !== 16'd1) begin
            failures++;
            $display("FAIL relocked got st=%0d rc=%0d exp st=1 rc=1", state, relock_cnt);
        end
    endtask

    // Continues from the LOCKED state left by test_relock (relock_cnt_o = 1).
    task automatic test_settle_fail;
        mon = '0;
        repeat (3) @(negedge clk);
        mon = 14'sd200;
        repeat (2) @(negedge clk);
        repeat (4) @(negedge clk);
        mon = '0;
        @(negedge clk);
        checks++;
        if (state !== 3'd3 || relock_cnt !== 16'd1 || ctr_val !== 14'sd0) begin
            failures++;
            $display("FAIL settle_drop got st=%0d rc=%0d cv=%0d exp st=3 rc=1 cv=0",
                     state, relock_cnt, ctr_val);
        end
        @(negedge clk);
        checks++;
        if (dat !== 14'sd0) begin
            failures++;
            $display("FAIL restart_0 got=%0d exp=0", dat);
        end
        @(negedge clk);
        checks++;
        if (dat !== 14'sd30) begin
            failures++;
            $display("FAIL restart_1 got=%0d exp=30", dat);
        end
        lock_en = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || relock_cnt !== 16'd0) begin
            failures++;
            $display("FAIL idle_clear got st=%0d rc=%0d exp st=0 rc=0", state, relock_cnt);
        end
    endtask

    task automatic test_priority;
        sweep_setup();
        go_locked();
        mon = '0;
        repeat (3) @(negedge clk);
        mon = 14'sd200;
        @(negedge clk);
        lock_en = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || int_rst !== 1'b1) begin
            failures++;
            $display("FAIL catch_abort got st=%0d ir=%b exp st=0 ir=1", state, int_rst);
        end
        lock_en = 1'b1;
        @(negedge clk);
        mon = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (dat !== 14'sd30 || state !== 3'd3) begin
            failures++;
            $display("FAIL pre_reset_sweep got st=%0d dat=%0d exp st=3 dat=30", state, dat);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dat !== 14'sd0 || state !== 3'd0 || ctr_val !== 14'sd0) begin
            failures++;
            $display("FAIL sweep_reset got st=%0d dat=%0d cv=%0d exp st=0 dat=0 cv=0",
                     state, dat, ctr_val);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_inverted_limits;
        set_defaults();
        lim_lo = 14'sd50;
        lim_hi = -14'sd50;
        do_reset();
        @(negedge clk);
        checks++;
        if (dat !== 14'sd50 || railed !== 2'b11) begin
            failures++;
            $display("FAIL inv_idle got dat=%0d rl=%b exp dat=50 rl=11", dat, railed);
        end
        lock_en = 1'b1;
        pid     = 14'sd20;
        repeat (2) @(negedge clk);
        checks++;
        if (dat !== 14'sd50 || railed !== 2'b11) begin
            failures++;
            $display("FAIL inv_locked got dat=%0d rl=%b exp dat=50 rl=11", dat, railed);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        set_defaults();
        test_reset();
        test_clamp();
        test_debounce();
        test_sweep();
        test_sweep_div();
        test_relock();
        test_settle_fail();
        test_priority();
        test_inverted_limits();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
